// File: rtl/sync_fifo_core_if.sv
// Handshake, data and status bundle for sync_fifo_core.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_core_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
);
    logic                         enq;
    logic                         deq;
    logic [WIDTH-1:0]             data_in;
    logic [WIDTH-1:0]             data_out;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output enq, deq, data_in,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  enq, deq, data_in,
        output data_out, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_core.sv
// Single-clock first-word-fall-through FIFO with registered overflow/underflow pulses.
// Any DEPTH >= 2 is supported; pointers wrap by compare rather than by natural overflow.
module sync_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              resetn,
    sync_fifo_core_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr_en = bus.enq & (~w_full | bus.deq);
    assign w_rd_en = bus.deq & ~w_empty;

    // NOTE: the storage array has no reset; validity is carried by the pointers
    // and count, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= bus.enq & ~w_wr_en;
            // A deq on empty masked by a simultaneous enq is not an underflow.
            r_underflow <= bus.deq & w_empty & ~bus.enq;
        end
    end

    assign bus.data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core: directed corner cases plus random traffic on DEPTH=8/WIDTH=32
// and DEPTH=5/WIDTH=8 instances, each checked every cycle against a queue model.
module tb_sync_fifo_core;
    logic clk;
    logic resetn;

    int n_vec;
    int n_err;

    sync_fifo_core_if #(.DEPTH(8), .WIDTH(32)) if8 ();
    sync_fifo_core_if #(.DEPTH(5), .WIDTH(8))  if5 ();

    sync_fifo_core #(.DEPTH(8), .WIDTH(32)) u_dut8 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if8)
    );

    sync_fifo_core #(.DEPTH(5), .WIDTH(8)) u_dut5 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is a queue with a capacity; flags follow the acceptance rules.
    logic [31:0] q8 [$];
    logic [7:0]  q5 [$];
    logic        m8_ovf, m8_unf, m5_ovf, m5_unf;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q8.delete();
            m8_ovf = 1'b0;
            m8_unf = 1'b0;
        end else begin
            automatic int  sz     = q8.size();
            automatic bit  wr_ok  = if8.enq && (sz < 8 || if8.deq);
            automatic bit  rd_ok  = if8.deq && sz > 0;
            m8_ovf = if8.enq && !wr_ok;
            m8_unf = if8.deq && sz == 0 && !if8.enq;
            if (rd_ok) void'(q8.pop_front());
            if (wr_ok) q8.push_back(if8.data_in);
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q5.delete();
            m5_ovf = 1'b0;
            m5_unf = 1'b0;
        end else begin
            automatic int  sz     = q5.size();
            automatic bit  wr_ok  = if5.enq && (sz < 5 || if5.deq);
            automatic bit  rd_ok  = if5.deq && sz > 0;
            m5_ovf = if5.enq && !wr_ok;
            m5_unf = if5.deq && sz == 0 && !if5.enq;
            if (rd_ok) void'(q5.pop_front());
            if (wr_ok) q5.push_back(if5.data_in);
        end
    end

    // Per-cycle comparison of both instances, away from the active edge.
    always @(negedge clk) begin
        check("d8.data_out",  if8.data_out,  (q8.size() > 0) ? q8[0] : 32'h0);
        check("d8.count",     32'(if8.count), 32'(q8.size()));
        check("d8.full",      32'(if8.full),  32'(q8.size() == 8));
        check("d8.empty",     32'(if8.empty), 32'(q8.size() == 0));
        check("d8.overflow",  32'(if8.overflow),  32'(m8_ovf));
        check("d8.underflow", 32'(if8.underflow), 32'(m8_unf));
        check("d5.data_out",  32'(if5.data_out), (q5.size() > 0) ? 32'(q5[0]) : 32'h0);
        check("d5.count",     32'(if5.count), 32'(q5.size()));
        check("d5.full",      32'(if5.full),  32'(q5.size() == 5));
        check("d5.empty",     32'(if5.empty), 32'(q5.size() == 0));
        check("d5.overflow",  32'(if5.overflow),  32'(m5_ovf));
        check("d5.underflow", 32'(if5.underflow), 32'(m5_unf));
    end

    // Drive DEPTH=8 inputs, cross one rising edge, return 1 time unit after it.
    task automatic step(input logic e, input logic d, input logic [31:0] din);
        if8.enq     = e;
        if8.deq     = d;
        if8.data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        if8.enq = 1'b0; if8.deq = 1'b0; if8.data_in = '0;
        if5.enq = 1'b0; if5.deq = 1'b0; if5.data_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.empty",    32'(if8.empty), 32'd1);
        check("rst.full",     32'(if8.full),  32'd0);
        check("rst.count",    32'(if8.count), 32'd0);
        check("rst.data_out", if8.data_out,   32'h0);
        resetn = 1'b1;
        step(1'b0, 1'b0, 32'h0);

        // Fill and drain order
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i * 'h11));
        check("fill.count",    32'(if8.count), 32'd8);
        check("fill.full",     32'(if8.full),  32'd1);
        check("fill.data_out", if8.data_out,   32'h11);
        for (int i = 1; i <= 8; i++) begin
            check("drain.head", if8.data_out, 32'(i * 'h11));
            step(1'b0, 1'b1, 32'h0);
        end
        check("drain.empty",    32'(if8.empty), 32'd1);
        check("drain.data_out", if8.data_out,   32'h0);

        // Overflow, then full with simultaneous enq/deq
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i * 'h11));
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("ovf.flag",  32'(if8.overflow), 32'd1);
        check("ovf.count", 32'(if8.count),    32'd8);
        step(1'b1, 1'b1, 32'h1234_5678);
        check("ovf.pulse_len", 32'(if8.overflow), 32'd0);
        check("both_full.count",    32'(if8.count), 32'd8);
        check("both_full.full",     32'(if8.full),  32'd1);
        check("both_full.data_out", if8.data_out,   32'h22);
        for (int i = 2; i <= 9; i++) begin
            check("both_full.drain", if8.data_out, (i == 9) ? 32'h1234_5678 : 32'(i * 'h11));
            step(1'b0, 1'b1, 32'h0);
        end
        check("both_full.empty", 32'(if8.empty), 32'd1);

        // Underflow, then enq/deq together on empty
        step(1'b0, 1'b1, 32'h0);
        check("unf.flag",  32'(if8.underflow), 32'd1);
        check("unf.count", 32'(if8.count),     32'd0);
        step(1'b1, 1'b1, 32'hA5A5_A5A5);
        check("both_empty.count",     32'(if8.count),     32'd1);
        check("both_empty.data_out",  if8.data_out,       32'hA5A5_A5A5);
        check("both_empty.underflow", 32'(if8.underflow), 32'd0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Asynchronous reset between edges with 3 entries stored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
        step(1'b0, 1'b0, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("arst.count",    32'(if8.count), 32'd0);
        check("arst.empty",    32'(if8.empty), 32'd1);
        check("arst.data_out", if8.data_out,   32'h0);
        @(negedge clk);
        #1;
        resetn = 1'b1;
        step(1'b0, 1'b0, 32'h0);

        // Random traffic on both instances; phases bias toward filling or draining
        for (int c = 0; c < 400; c++) begin
            automatic int wr_pct = ((c / 25) % 2 == 0) ? 75 : 35;
            if8.enq     = ($urandom_range(0, 99) < wr_pct);
            if8.deq     = ($urandom_range(0, 99) < 55);
            if8.data_in = $urandom;
            if5.enq     = ($urandom_range(0, 99) < wr_pct);
            if5.deq     = ($urandom_range(0, 99) < 55);
            if5.data_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        if8.enq = 1'b0; if8.deq = 1'b0;
        if5.enq = 1'b0; if5.deq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
